alarm_snooze_ctrl: RTL and testbench
====================================

# alarm_snooze_ctrl

Downstream companion to the alarm clock core. Consumes the latched `Alarm` level, drives the buzzer with a 1 Hz on/off pattern, and handles snooze and dismiss buttons. It returns a one-cycle `STOP_al` pulse to the clock core so that core's alarm latch is cleared. Runs entirely on the 1 Hz `clk_1s` domain.

## Interface
Parameters:
- `SNOOZE_SEC`, default 300: snooze length in seconds (legal range 1..1023).
- `MAX_SNOOZE`, default 3: maximum snoozes per alarm event (0..7); 0 disables snooze.
- `RING_TIMEOUT`, default 60: ring duration in seconds before the timeout action (1..255).

Ports:
- `clk_1s`  in  1  1 Hz clock; all state advances on its rising edge.
- `reset`  in  1  Asynchronous, active-high reset.
- `alarm_in`  in  1  `Alarm` level from the clock core.
- `snooze_btn`  in  1  Snooze request; level, already synchronous to `clk_1s`.
- `dismiss_btn`  in  1  Dismiss request; level, already synchronous to `clk_1s`.
- `stop_al`  out  1  Registered one-cycle pulse; connects to the clock core's `STOP_al`.
- `buzzer`  out  1  Registered buzzer drive.
- `ringing`  out  1  High while state = RINGING.
- `snoozing`  out  1  High while state = SNOOZE.
- `snooze_cnt`  out  3  Number of snoozes used in the current event.
- `snz_remain`  out  10  Seconds left in the current snooze; 0 outside SNOOZE.

## Operation
- FSM states: IDLE, RINGING, SNOOZE, WAIT_CLR.
- Reset drives: state = IDLE; `stop_al`, `buzzer`, `snooze_cnt`, `snz_remain` and the internal `ring_cnt` (8 bit) all = 0.
- **IDLE**
  - If `alarm_in` = 1: go to RINGING, `ring_cnt` <= 0, `buzzer` <= 1.
  - Both buttons are ignored.
- **RINGING**, evaluated in priority order:
  1. `dismiss_btn` = 1: go to WAIT_CLR, `stop_al` <= 1, `buzzer` <= 0.
  2. `snooze_btn` = 1 and `snooze_cnt` < `MAX_SNOOZE`: go to SNOOZE, `stop_al` <= 1, `buzzer` <= 0, `snooze_cnt` += 1, `snz_remain` <= `SNOOZE_SEC`.
  3. `snooze_btn` with no snoozes left: ignored; treat as no button.
  4. `ring_cnt` == `RING_TIMEOUT`-1: timeout action (see Configuration).
  5. Otherwise: `ring_cnt` += 1, `buzzer` toggles.
- **SNOOZE**
  - `alarm_in` and `snooze_btn` are ignored.
  - `dismiss_btn` = 1: go to WAIT_CLR, `snz_remain` <= 0. `stop_al` is not pulsed, because the core latch is already clear.
  - `snz_remain` == 1: go to RINGING, `snz_remain` <= 0, `ring_cnt` <= 0, `buzzer` <= 1.
  - Otherwise: `snz_remain` -= 1.
- **WAIT_CLR**
  - `alarm_in` = 0: go to IDLE, `snooze_cnt` <= 0.
  - Otherwise stay. This prevents re-triggering on the core's still-high latch.
- `ringing` and `snoozing` decode the state register combinationally.
- No arithmetic wraps:
  - `snooze_cnt` is bounded by `MAX_SNOOZE`.
  - `snz_remain` never decrements below 1 in SNOOZE.
  - `ring_cnt` never exceeds `RING_TIMEOUT`-1.

## Timing
- Alarm to buzzer:
  - Core asserts `Alarm` after edge k.
  - IDLE samples it at edge k+1; `buzzer` = 1 after edge k+1.
- Buzzer pattern: 1,0,1,0,… one value per second, starting at 1.
- Ringing length: exactly `RING_TIMEOUT` cycles in RINGING before the timeout action.
- `stop_al` handshake:
  - `stop_al` is high for exactly the one cycle following the exit edge k.
  - The core samples it at k+1, and `alarm_in` falls after k+1.
  - WAIT_CLR returns to IDLE at k+2.
- Snooze length: exactly `SNOOZE_SEC` cycles in SNOOZE before ringing resumes.
- Button width: a button held for many cycles acts once. The state change makes later samples irrelevant.
- Simultaneous events:
  - Dismiss wins over snooze and over timeout.
  - Snooze wins over timeout.
  - In SNOOZE, dismiss wins over expiry.
- Reset mid-operation: immediate return to reset values, including mid-pulse `stop_al`.

## Configuration
- Macro: `ALARM_AUTO_SNOOZE_EN`.
- **Defined:** the RINGING timeout performs the snooze action (rule 2) if `snooze_cnt` < `MAX_SNOOZE`; otherwise it performs the dismiss action (rule 1).
- **Undefined:** the timeout always performs the dismiss action.

## Test plan
All scenarios use `SNOOZE_SEC`=5, `MAX_SNOOZE`=2, `RING_TIMEOUT`=4.
- Raise `alarm_in` at edge 0 -> `buzzer` = 1,0,1,0 after edges 1–4; then `stop_al` = 1 for one cycle. With the macro: `snoozing`=1, `snz_remain`=5, `snooze_cnt`=1. Without the macro: WAIT_CLR.
- Ringing, pulse `snooze_btn` -> `stop_al` pulse; `snz_remain` counts 5,4,3,2,1 on successive cycles; RINGING re-entered with `buzzer`=1 on the 6th edge.
- Snooze twice, then press `snooze_btn` on the third ring -> ignored; `buzzer` keeps toggling; `snooze_cnt` stays 2.
- Assert `snooze_btn` and `dismiss_btn` together while ringing -> WAIT_CLR, `snooze_cnt` unchanged. Drop `alarm_in` one edge later -> IDLE with `snooze_cnt`=0 one edge after that.
- Hold `alarm_in` high while in WAIT_CLR -> stays in WAIT_CLR with no re-ring. Release -> IDLE.
- Assert `reset` asynchronously mid-SNOOZE at `snz_remain`=3 -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: buzzer, snooze and dismiss handling downstream of the
// alarm clock core, running on the 1 Hz clk_1s domain.
// Optional feature: define ALARM_AUTO_SNOOZE_EN so that a ring timeout snoozes
// while snoozes remain (and dismisses once they run out). Without the macro,
// a ring timeout always dismisses.
module alarm_snooze_ctrl #(
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3,
    parameter int RING_TIMEOUT = 60
) (
    input  logic       clk_1s,
    input  logic       reset,
    input  logic       alarm_in,
    input  logic       snooze_btn,
    input  logic       dismiss_btn,
    output logic       stop_al,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt,
    output logic [9:0] snz_remain
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZE   = 2'd2,
        WAIT_CLR = 2'd3
    } state_t;

    localparam logic [9:0] SNZ_LOAD  = 10'(SNOOZE_SEC);
    localparam logic [2:0] SNZ_MAX   = 3'(MAX_SNOOZE);
    localparam logic [7:0] RING_LAST = 8'(RING_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       stop_al_q, stop_al_d;
    logic       buzzer_q, buzzer_d;
    logic [2:0] snooze_cnt_q, snooze_cnt_d;
    logic [9:0] snz_remain_q, snz_remain_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;

    logic can_snooze;
    logic take_dismiss;
    logic take_snooze;

    assign can_snooze = (snooze_cnt_q < SNZ_MAX);

    // Next-state and next-output computation for the alarm FSM.
    always_comb begin
        state_d      = state_q;
        stop_al_d    = 1'b0;
        buzzer_d     = buzzer_q;
        snooze_cnt_d = snooze_cnt_q;
        snz_remain_d = snz_remain_q;
        ring_cnt_d   = ring_cnt_q;
        take_dismiss = 1'b0;
        take_snooze  = 1'b0;

        case (state_q)
            IDLE: begin
                if (alarm_in) begin
                    state_d    = RINGING;
                    ring_cnt_d = 8'd0;
                    buzzer_d   = 1'b1;
                end
            end

            RINGING: begin
                // A snooze press with no snoozes left falls through as if idle.
                if (dismiss_btn) begin
                    take_dismiss = 1'b1;
                end else if (snooze_btn && can_snooze) begin
                    take_snooze = 1'b1;
                end else if (ring_cnt_q == RING_LAST) begin
`ifdef ALARM_AUTO_SNOOZE_EN
                    if (can_snooze) begin
                        take_snooze = 1'b1;
                    end else begin
                        take_dismiss = 1'b1;
                    end
`else
                    take_dismiss = 1'b1;
`endif
                end else begin
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    buzzer_d   = ~buzzer_q;
                end

                if (take_dismiss) begin
                    state_d   = WAIT_CLR;
                    stop_al_d = 1'b1;
                    buzzer_d  = 1'b0;
                end
                if (take_snooze) begin
                    state_d      = SNOOZE;
                    stop_al_d    = 1'b1;
                    buzzer_d     = 1'b0;
                    snooze_cnt_d = snooze_cnt_q + 3'd1;
                    snz_remain_d = SNZ_LOAD;
                end
            end

            SNOOZE: begin
                // The core latch was cleared on snooze entry, so no stop pulse here.
                if (dismiss_btn) begin
                    state_d      = WAIT_CLR;
                    snz_remain_d = 10'd0;
                end else if (snz_remain_q == 10'd1) begin
                    state_d      = RINGING;
                    snz_remain_d = 10'd0;
                    ring_cnt_d   = 8'd0;
                    buzzer_d     = 1'b1;
                end else begin
                    snz_remain_d = snz_remain_q - 10'd1;
                end
            end

            WAIT_CLR: begin
                // Hold here until the core latch drops so it cannot re-trigger.
                if (!alarm_in) begin
                    state_d      = IDLE;
                    snooze_cnt_d = 3'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk_1s or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            stop_al_q    <= 1'b0;
            buzzer_q     <= 1'b0;
            snooze_cnt_q <= 3'd0;
            snz_remain_q <= 10'd0;
            ring_cnt_q   <= 8'd0;
        end else begin
            state_q      <= state_d;
            stop_al_q    <= stop_al_d;
            buzzer_q     <= buzzer_d;
            snooze_cnt_q <= snooze_cnt_d;
            snz_remain_q <= snz_remain_d;
            ring_cnt_q   <= ring_cnt_d;
        end
    end

    assign stop_al    = stop_al_q;
    assign buzzer     = buzzer_q;
    assign snooze_cnt = snooze_cnt_q;
    assign snz_remain = snz_remain_q;
    assign ringing    = (state_q == RINGING);
    assign snoozing   = (state_q == SNOOZE);

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Scoreboard bench for alarm_snooze_ctrl with SNOOZE_SEC=5, MAX_SNOOZE=2,
// RING_TIMEOUT=4. Follows ALARM_AUTO_SNOOZE_EN when it is defined.
module tb_alarm_snooze_ctrl;

    localparam int SNZ  = 5;
    localparam int MAXS = 2;
    localparam int RT   = 4;

    logic       clk_1s = 1'b0;
    logic       reset = 1'b1;
    logic       alarm_in = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       dismiss_btn = 1'b0;
    logic       stop_al, buzzer, ringing, snoozing;
    logic [2:0] snooze_cnt;
    logic [9:0] snz_remain;

    alarm_snooze_ctrl #(
        .SNOOZE_SEC(SNZ), .MAX_SNOOZE(MAXS), .RING_TIMEOUT(RT)
    ) dut (
        .clk_1s(clk_1s), .reset(reset), .alarm_in(alarm_in),
        .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
        .stop_al(stop_al), .buzzer(buzzer), .ringing(ringing),
        .snoozing(snoozing), .snooze_cnt(snooze_cnt), .snz_remain(snz_remain)
    );

    always #5 clk_1s = ~clk_1s;

    typedef struct {
        int stop;
        int buz;
        int rng;
        int snzg;
        int cnt;
        int rem;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: the alarm's life described by mode plus elapsed/remaining seconds.
    localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2, M_WAIT = 3;
    int m_mode = M_IDLE;
    int m_ring_t = 0;   // seconds since ringing (re)started
    int m_left = 0;     // seconds of snooze left
    int m_used = 0;     // snoozes taken this event
    int m_stop = 0;     // stop pulse currently presented

    // Clock-core alarm latch emulation.
    bit latch = 0;
    bit clr_pending = 0;
    bit rst_drv = 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_ring_t = 0; m_left = 0; m_used = 0; m_stop = 0;
    endtask

    task automatic model_step(input bit a, input bit s, input bit d, input bit r);
        int  nstop;
        bit  do_dis, do_snz;
        nstop = 0; do_dis = 0; do_snz = 0;
        if (r) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_IDLE: if (a) begin m_mode = M_RING; m_ring_t = 0; end
            M_RING: begin
                if (d) do_dis = 1;
                else if (s && m_used < MAXS) do_snz = 1;
                else if (m_ring_t == RT - 1) begin
`ifdef ALARM_AUTO_SNOOZE_EN
                    if (m_used < MAXS) do_snz = 1; else do_dis = 1;
`else
                    do_dis = 1;
`endif
                end else m_ring_t++;
                if (do_dis) begin m_mode = M_WAIT; nstop = 1; end
                if (do_snz) begin m_mode = M_SNZ; nstop = 1; m_used++; m_left = SNZ; end
            end
            M_SNZ: begin
                if (d) begin m_mode = M_WAIT; m_left = 0; end
                else if (m_left == 1) begin m_mode = M_RING; m_left = 0; m_ring_t = 0; end
                else m_left--;
            end
            default: if (!a) begin m_mode = M_IDLE; m_used = 0; end
        endcase
        m_stop = nstop;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.stop = m_stop;
        e.rng  = (m_mode == M_RING) ? 1 : 0;
        e.snzg = (m_mode == M_SNZ) ? 1 : 0;
        e.buz  = (m_mode == M_RING && (m_ring_t % 2) == 0) ? 1 : 0;
        e.cnt  = m_used;
        e.rem  = m_left;
        return e;
    endfunction

    // One clock of stimulus: drive on the falling edge, predict the next rising edge.
    task automatic cyc(input bit trig, input bit s, input bit d, input bit hold);
        @(negedge clk_1s);
        if (clr_pending) latch = 0;
        clr_pending = (m_stop != 0);
        if (trig) latch = 1;
        alarm_in    = latch | hold;
        snooze_btn  = s;
        dismiss_btn = d;
        reset       = rst_drv;
        model_step(alarm_in, s, d, rst_drv);
        exp_q.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic settle();
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        idle(3);
    endtask

    // Monitor: after every rising edge, compare DUT outputs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_1s);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stop_al", int'(stop_al), e.stop);
                chk("buzzer", int'(buzzer), e.buz);
                chk("ringing", int'(ringing), e.rng);
                chk("snoozing", int'(snoozing), e.snzg);
                chk("snooze_cnt", int'(snooze_cnt), e.cnt);
                chk("snz_remain", int'(snz_remain), e.rem);
            end
        end
    end

    initial begin
        #2;
        chk("reset_stop_al", int'(stop_al), 0);
        chk("reset_buzzer", int'(buzzer), 0);
        chk("reset_state", int'({ringing, snoozing}), 0);
        rst_drv = 1;
        idle(2);
        rst_drv = 0;
        idle(2);

        // Free-running ring up to the timeout action.
        cyc(1, 0, 0, 0); idle(8); settle();
        // Single snooze, then expiry back to ringing.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(8); settle();
        // Exhaust snoozes, then a held snooze on the third ring is ignored.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(6);
        cyc(0, 1, 0, 0); idle(6);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        settle();
        // Snooze and dismiss together while ringing.
        cyc(1, 0, 0, 0); cyc(0, 1, 1, 0); idle(4);
        // Alarm held high through WAIT_CLR, then released.
        cyc(1, 0, 0, 0); cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        idle(3);
        // Asynchronous reset mid-snooze at snz_remain = 3.
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); idle(2);
        @(posedge clk_1s);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_stop_al", int'(stop_al), 0);
        chk("async_rst_buzzer", int'(buzzer), 0);
        chk("async_rst_ringing", int'(ringing), 0);
        chk("async_rst_snoozing", int'(snoozing), 0);
        chk("async_rst_snooze_cnt", int'(snooze_cnt), 0);
        chk("async_rst_snz_remain", int'(snz_remain), 0);
        model_reset();
        rst_drv = 1;
        cyc(0, 0, 0, 0);
        rst_drv = 0;
        idle(3);

        // Randomized traffic with an emulated core latch.
        for (int i = 0; i < 3000; i++) begin
            rst_drv = ($urandom_range(0, 399) == 0);
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 14) == 0, 1'b0);
        end
        rst_drv = 0;
        idle(2);
        @(posedge clk_1s);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
